sw_debounce: RTL and testbench
==============================

# sw_debounce

Input conditioner that sits directly upstream of the picoMIPS top level, between the raw board slide switches and the processor's switch input vector. Each switch bit is synchronised with a two-flop chain, then debounced with a per-bit stability counter. The result is a glitch-free `sw_clean` vector, including the highest bit, which drives the processor reset. An optional one-cycle `changed` strobe marks every update of the clean vector.

## Interface
Parameters:
- `WIDTH`, default 10: number of switch bits conditioned.
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive clocks a synchronised bit must differ from its clean value before the clean value updates. Legal range is ≥1.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES)`, minimum 1: per-bit counter width.

Ports:
- `clk`, in, 1: system clock, the same clock as the processor.
- `reset`, in, 1: asynchronous, active-low reset.
- `sw_raw`, in, `WIDTH`: raw, asynchronous switch levels.
- `sw_clean`, out, `WIDTH`: debounced levels, fed to the processor switch input.
- `changed`, out, 1: one-cycle pulse, high in the cycle any `sw_clean` bit has just changed.

## Operation
- Reset, while `reset`=0:
  - both synchroniser stages cleared to 0;
  - all counters cleared to 0;
  - `sw_clean`=0;
  - `changed`=0.
  - Reset takes effect immediately and asynchronously, including in the middle of a count.
- Synchroniser: `s1 <= sw_raw` and `s2 <= s1`, per bit. Only `s2` is used downstream.
- Per-bit counter rule, evaluated every clock:
  - `s2[i] == sw_clean[i]`: `cnt[i] <= 0`, `sw_clean[i]` held.
  - `s2[i] != sw_clean[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `s2[i] != sw_clean[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_clean[i] <= s2[i]`, `cnt[i] <= 0`.
- Any single cycle in which `s2` returns to the clean value restarts that bit's count from 0. Bounces shorter than `DEBOUNCE_CYCLES` never reach the output.
- Bits are independent. Several bits may update on the same edge.
- Counters never wrap: the terminal count always clears the counter in the same edge that updates the clean bit.
- `changed <= |(next_clean ^ sw_clean)`, registered together with `sw_clean`.
  - Exactly one pulse per updating edge, regardless of how many bits change.
  - Consecutive updates on adjacent edges give `changed` high on consecutive cycles.

## Timing
- Latency from a stable `sw_raw` transition (sampled at edge 0) to `sw_clean` update is `DEBOUNCE_CYCLES+2` clocks:
  - 2 clocks of synchroniser;
  - `DEBOUNCE_CYCLES` clocks of counting.
- `changed` is high in exactly the cycle following the `sw_clean` updating edge, and low otherwise.
- `DEBOUNCE_CYCLES=1`: latency is 3 clocks, and any one-cycle difference in `s2` propagates.
- After reset release, the first clean update for a raw level of 1 takes the full `DEBOUNCE_CYCLES+2` clocks. There is no pre-load from the switches.
- All outputs are registered. There are no combinational paths from `sw_raw` or `reset` to outputs, except the asynchronous clear.

## Configuration
- Macro `SW_CHANGE_PULSE_EN`:
  - Defined: the `changed` register and its XOR/OR reduction are built exactly as described above.
  - Undefined: `changed` is tied to constant 0 and no logic is generated for it. `sw_clean` behaviour is identical in both builds.

## Test plan
All scenarios use `WIDTH`=10 and `DEBOUNCE_CYCLES`=8.
1. Hold `reset`=0 with `sw_raw`=10'h3FF, then release and hold `sw_raw`=0 for 20 clocks → `sw_clean`=0 and `changed`=0 throughout.
2. After reset, set `sw_raw`=10'h001 at edge 0 → `sw_clean` becomes 10'h001 at edge 10 (not before), and `changed`=1 for exactly one cycle after edge 10.
3. Toggle `sw_raw[3]` every 5 clocks for 40 clocks, then hold it at 1 → `sw_clean[3]` stays 0 during the toggling and rises exactly 10 clocks after the final edge. Other bits stay 0.
4. Change `sw_raw` from 0 to 10'h3FF on one edge → all ten `sw_clean` bits update on the same edge, 10 clocks later, with a single one-cycle `changed` pulse.
5. Set `sw_raw`=10'h200, then assert `reset`=0 for 2 clocks starting at clock 6 (mid-count) and release → `sw_clean`=0 immediately on assertion, and `sw_clean[9]` rises 10 clocks after release (full recount).
6. Build without `SW_CHANGE_PULSE_EN` and repeat scenario 4 → `sw_clean` timing is identical, and `changed` is constant 0.

Source files
------------

// File: rtl/sw_debounce.sv
// ============================================================================
//  Module      : sw_debounce
//  Description : Slide-switch conditioner. Each raw switch bit passes through
//                a two-flop synchroniser and a per-bit stability counter; the
//                clean level only follows the synchronised level after it has
//                disagreed for DEBOUNCE_CYCLES consecutive clocks.
//                Optional macro SW_CHANGE_PULSE_EN builds the one-cycle
//                'changed' strobe; without it 'changed' is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             changed
);

  // Terminal count: the clean bit updates on the edge where the counter
  // already holds this value, so DEBOUNCE_CYCLES disagreeing edges in total.
  localparam logic [CNT_WIDTH-1:0] c_CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     r_s1;
  logic [WIDTH-1:0]     r_s2;
  logic [WIDTH-1:0]     r_clean;
  logic [CNT_WIDTH-1:0] r_cnt      [WIDTH];
  logic [WIDTH-1:0]     w_next_clean;
  logic [CNT_WIDTH-1:0] w_next_cnt [WIDTH];

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-bit stability rule: any agreement restarts the count, the terminal
  // count takes the new level and clears the counter in the same edge.
  always_comb begin
    w_next_clean = r_clean;
    for (int i = 0; i < WIDTH; i++) begin
      w_next_cnt[i] = '0;
      if (r_s2[i] != r_clean[i]) begin
        if (r_cnt[i] == c_CNT_TERM) begin
          w_next_clean[i] = r_s2[i];
        end else begin
          w_next_cnt[i] = r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter and clean-level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clean <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_clean <= w_next_clean;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_next_cnt[i];
      end
    end
  end

  assign sw_clean = r_clean;

`ifdef SW_CHANGE_PULSE_EN
  logic r_changed;

  // One pulse per updating edge, however many bits flip on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_next_clean ^ r_clean);
    end
  end

  assign changed = r_changed;
`else
  assign changed = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce.sv
// ============================================================================
//  Module      : tb_sw_debounce
//  Description : Self-checking bench for sw_debounce (WIDTH=10,
//                DEBOUNCE_CYCLES=8): directed scenarios with literal
//                expectations plus randomized switch activity compared each
//                cycle against a window-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sw_debounce;

  localparam int W  = 10;
  localparam int DC = 8;
`ifdef SW_CHANGE_PULSE_EN
  localparam logic c_PULSE = 1'b1;
`else
  localparam logic c_PULSE = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean;
  logic         changed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .changed (changed)
  );

  // Behavioural model: the clean level of a bit flips when the last DC
  // synchronised samples it was judged against all disagree with it.
  logic [W-1:0] m_d1    = '0;   // raw value two edges back pipeline
  logic [W-1:0] m_d2    = '0;
  logic [W-1:0] m_clean = '0;
  logic         m_chg   = 1'b0;
  logic [W-1:0] m_hist[$];

  function automatic void model_clear();
    m_d1    = '0;
    m_d2    = '0;
    m_clean = '0;
    m_chg   = 1'b0;
    m_hist.delete();
  endfunction

  always @(negedge reset) model_clear();

  always @(posedge clk) begin : p_model
    logic [W-1:0] nxt;
    bit           run;
    if (!reset) begin
      model_clear();
    end else begin
      m_hist.push_back(m_d2);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      nxt = m_clean;
      for (int i = 0; i < W; i++) begin
        run = (m_hist.size() == DC);
        foreach (m_hist[j]) if (m_hist[j][i] == m_clean[i]) run = 1'b0;
        if (run) nxt[i] = ~m_clean[i];
      end
      m_chg   = c_PULSE & (nxt != m_clean);
      m_clean = nxt;
      m_d2    = m_d1;
      m_d1    = sw_raw;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("model_clean",   sw_clean,           m_clean);
      chk("model_changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, m_chg});
    end
  end

  task automatic do_reset(input logic [W-1:0] raw_in, input logic [W-1:0] raw_after);
    @(negedge clk);
    reset  = 1'b0;
    sw_raw = raw_in;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    sw_raw = raw_after;
  endtask

  // Drive 'value' just after edge 0 and pin the update at edge DC+2.
  task automatic step_test(input string tag, input logic [W-1:0] value);
    @(negedge clk);
    sw_raw = value;
    for (int k = 1; k <= DC + 3; k++) begin
      @(posedge clk);
      #1;
      if (k == DC + 1) chk({tag, "_before"}, sw_clean, '0);
      if (k == DC + 2) begin
        chk({tag, "_update"}, sw_clean, value);
        chk({tag, "_pulse"},  {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, c_PULSE});
      end
      if (k == DC + 3) chk({tag, "_pulse_end"}, {{(W-1){1'b0}}, changed}, '0);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    sw_raw = 10'h3FF;

    // Scenario 1: reset with all switches high, release with all low.
    do_reset(10'h3FF, 10'h000);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("s1_clean", sw_clean, '0);
      chk("s1_changed", {{(W-1){1'b0}}, changed}, '0);
    end

    // Scenario 2: single bit, exact latency.
    do_reset('0, '0);
    repeat (3) @(posedge clk);
    step_test("s2", 10'h001);

    // Scenario 3: bit 3 bouncing with 5-cycle periods never passes.
    do_reset('0, '0);
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) sw_raw[3] = ((t / 5) % 2 == 0);
      @(posedge clk);
      #1;
      chk("s3_bounce", sw_clean, '0);
      @(negedge clk);
    end
    sw_raw[3] = 1'b1;
    for (int k = 1; k <= DC + 2; k++) begin
      @(posedge clk);
      #1;
      if (k == DC + 1) chk("s3_before", sw_clean, '0);
      if (k == DC + 2) chk("s3_update", sw_clean, 10'h008);
    end

    // Scenario 4 (and 6 when the pulse macro is absent): all bits together.
    do_reset('0, '0);
    repeat (2) @(posedge clk);
    step_test("s4", 10'h3FF);

    // Scenario 5: reset in the middle of a count forces a full recount.
    do_reset('0, 10'h001);
    repeat (DC + 4) @(posedge clk);
    #1;
    chk("s5_preload", sw_clean, 10'h001);
    @(negedge clk);
    sw_raw = 10'h201;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("s5_async_clear", sw_clean, '0);
    chk("s5_async_changed", {{(W-1){1'b0}}, changed}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= DC + 2; k++) begin
      @(posedge clk);
      #1;
      if (k == DC + 1) chk("s5_before", sw_clean, '0);
      if (k == DC + 2) chk("s5_recount", sw_clean, 10'h201);
    end

    // Randomized activity with occasional resets; the model does the checking.
    do_reset('0, '0);
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 999);
      if (r < 120) begin
        sw_raw = sw_raw ^ W'($urandom);
      end else if (r < 140) begin
        sw_raw = W'($urandom);
      end else if (r < 143) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
    end
    repeat (DC + 4) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
